// File: rtl/mux_arbiter.sv
// mux_arbiter: three-requester round-robin arbiter with a shared data mux.
// An owner keeps the grant for up to MAX_BEATS transfers. The grant is
// released early when the owner drops its request. Each release passes
// through exactly one IDLE cycle before the next arbitration.
//
// Handshake: a beat is transferred in any cycle where out_valid and out_ready
// are both high. out_valid is high only while the owner still requests, and
// it does not depend on out_ready. The sink may stall with out_ready low for
// any number of cycles, and the grant holds with no timeout.
//
// The FSM state is visible on the busy output (busy == GRANT).
module mux_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             out_ready,
  output logic [2:0]       gnt,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             busy
);

  localparam logic [3:0] LP_LAST_BEAT = 4'(MAX_BEATS - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] r_gnt;
  logic [3:0] r_beat;
  logic [1:0] r_last;
  logic [2:0] w_win_gnt;
  logic [1:0] w_owner_idx;
  logic       w_owner_req;
  logic       w_beat;
  logic       w_release;

  assign w_owner_req = |(req & r_gnt);
  assign w_beat      = out_valid & out_ready;
  assign w_release   = (r_state == S_GRANT) &&
                       (!w_owner_req || (w_beat && (r_beat == LP_LAST_BEAT)));
  assign gnt         = r_gnt;

  // Encode the one-hot grant as an index, so the releasing owner can be stored in r_last.
  always_comb begin
    w_owner_idx = 2'd0;
    if (r_gnt[1])      w_owner_idx = 2'd1;
    else if (r_gnt[2]) w_owner_idx = 2'd2;
  end

  // Round-robin pick: the first requester after the last owner, wrapping modulo 3.
  always_comb begin
    w_win_gnt = 3'b000;
    case (r_last)
      2'd0: begin
        if (req[1])      w_win_gnt = 3'b010;
        else if (req[2]) w_win_gnt = 3'b100;
        else if (req[0]) w_win_gnt = 3'b001;
      end
      2'd1: begin
        if (req[2])      w_win_gnt = 3'b100;
        else if (req[0]) w_win_gnt = 3'b001;
        else if (req[1]) w_win_gnt = 3'b010;
      end
      default: begin
        if (req[0])      w_win_gnt = 3'b001;
        else if (req[1]) w_win_gnt = 3'b010;
        else if (req[2]) w_win_gnt = 3'b100;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic: arbitrate in IDLE, and return to IDLE on any release.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (req != 3'b000) w_next_state = S_GRANT;
      S_GRANT: if (w_release)     w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Grant, beat counter and last-owner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt  <= 3'b000;
      r_beat <= 4'd0;
      r_last <= 2'd2;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req != 3'b000) begin
            r_gnt  <= w_win_gnt;
            r_beat <= 4'd0;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_gnt  <= 3'b000;
            r_last <= w_owner_idx;
          end else if (w_beat) begin
            r_beat <= r_beat + 4'd1;
          end
        end
        default: r_gnt <= 3'b000;
      endcase
    end
  end

  // Outputs: busy flag, valid qualified by the owner's live request, and the data mux.
  always_comb begin
    busy      = (r_state == S_GRANT);
    out_valid = busy & w_owner_req;
    out_data  = '0;
    case (r_gnt)
      3'b001:  out_data = data0;
      3'b010:  out_data = data1;
      3'b100:  out_data = data2;
      default: out_data = '0;
    endcase
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed scenarios followed by random traffic. Two instances
// share the same inputs: one with MAX_BEATS=4 and one with MAX_BEATS=1. Each
// instance is compared against an owner/beat-count reference model.
module tb_mux_arbiter;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic [7:0] data0, data1, data2;
  logic       out_ready;
  logic [2:0] gnt_a, gnt_b;
  logic [7:0] out_data_a, out_data_b;
  logic       out_valid_a, out_valid_b, busy_a, busy_b;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] exp_q[$];

  // Reference model: owner index (-1 = none), beats done, last owner.
  int m_owner[2];
  int m_beats[2];
  int m_last[2];
  int m_max[2] = '{4, 1};

  mux_arbiter #(.WIDTH(8), .MAX_BEATS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .data0(data0), .data1(data1),
    .data2(data2), .out_ready(out_ready), .gnt(gnt_a), .out_data(out_data_a),
    .out_valid(out_valid_a), .busy(busy_a)
  );

  mux_arbiter #(.WIDTH(8), .MAX_BEATS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .data0(data0), .data1(data1),
    .data2(data2), .out_ready(out_ready), .gnt(gnt_b), .out_data(out_data_b),
    .out_valid(out_valid_b), .busy(busy_b)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input int last, input logic [2:0] r);
    for (int i = 1; i <= 3; i++) begin
      if (r[(last + i) % 3]) return (last + i) % 3;
    end
    return -1;
  endfunction

  function automatic logic [7:0] sel_data(input int o);
    case (o)
      0:       return data0;
      1:       return data1;
      2:       return data2;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_beats[k] = 0;
      m_last[k]  = 2;
    end
  endtask

  task automatic model_advance(input logic [2:0] r, input logic rdy);
    for (int k = 0; k < 2; k++) begin
      if (m_owner[k] < 0) begin
        if (r != 3'b000) begin
          m_owner[k] = winner(m_last[k], r);
          m_beats[k] = 0;
        end
      end else if (!r[m_owner[k]]) begin
        m_last[k]  = m_owner[k];
        m_owner[k] = -1;
      end else if (rdy) begin
        if (m_beats[k] + 1 == m_max[k]) begin
          m_last[k]  = m_owner[k];
          m_owner[k] = -1;
        end else begin
          m_beats[k]++;
        end
      end
    end
  endtask

  // Compare both instances against the model for the current cycle.
  task automatic check_model();
    logic [2:0] g;
    logic [7:0] d;
    logic       v, b;
    for (int k = 0; k < 2; k++) begin
      g = (k == 0) ? gnt_a : gnt_b;
      d = (k == 0) ? out_data_a : out_data_b;
      v = (k == 0) ? out_valid_a : out_valid_b;
      b = (k == 0) ? busy_a : busy_b;
      check($sformatf("gnt[%0d]", k), 32'(g),
            (m_owner[k] < 0) ? 32'd0 : (32'd1 << m_owner[k]));
      check($sformatf("valid[%0d]", k), 32'(v),
            32'((m_owner[k] >= 0) && req[m_owner[k]]));
      check($sformatf("data[%0d]", k), 32'(d), 32'(sel_data(m_owner[k])));
      check($sformatf("busy[%0d]", k), 32'(b), 32'(m_owner[k] >= 0));
      check($sformatf("onehot[%0d]", k), 32'($onehot0(g)), 32'd1);
    end
  endtask

  // Driver: one cycle. Drive at the falling edge, then check 1 ns later.
  task automatic step(input logic [2:0] r, input logic rdy);
    @(negedge clk);
    req       = r;
    out_ready = rdy;
    #1;
    check_model();
    model_advance(r, rdy);
  endtask

  // Reset asserted between clock edges. Outputs must clear before any edge.
  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_gnt_a", 32'(gnt_a), 32'd0);
    check("rst_gnt_b", 32'(gnt_b), 32'd0);
    check("rst_valid", 32'({out_valid_a, out_valid_b}), 32'd0);
    check("rst_busy", 32'({busy_a, busy_b}), 32'd0);
    check("rst_data", 32'({out_data_a, out_data_b}), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] cur_req;
    rst_n = 1'b0; req = 3'b000; out_ready = 1'b0;
    data0 = 8'h00; data1 = 8'h11; data2 = 8'h22;
    model_reset();
    @(negedge clk);
    async_reset();

    // Single requester: 4 beats, one IDLE cycle, then granted again.
    data0 = 8'hA5;
    step(3'b001, 1'b1);
    check("r032_idle0", 32'(gnt_a), 32'b000);
    for (int i = 0; i < 4; i++) begin
      step(3'b001, 1'b1);
      check("r032_gnt", 32'(gnt_a), 32'b001);
      check("r032_data", 32'({out_valid_a, out_data_a}), 32'h1A5);
    end
    step(3'b001, 1'b1);
    check("r032_gap", 32'(gnt_a), 32'b000);
    step(3'b000, 1'b1);
    check("r032_regrant", 32'(gnt_a), 32'b001);
    step(3'b000, 1'b1);

    // Owner 1 stalled for 5 cycles, then 4 beats in total.
    data1 = 8'h3C;
    step(3'b010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(3'b010, 1'b0);
      check("r034_stall", 32'({gnt_a, out_valid_a, busy_a}), 32'b01011);
    end
    for (int i = 0; i < 4; i++) begin
      step(3'b010, 1'b1);
      check("r034_beat", 32'({gnt_a, out_data_a}), 32'h23C);
    end
    step(3'b000, 1'b1);
    check("r034_done", 32'(gnt_a), 32'b000);

    // Owner 2 drops its request after 2 beats; requester 0 is next.
    step(3'b101, 1'b1);
    step(3'b101, 1'b1);
    step(3'b101, 1'b1);
    check("r035_own2", 32'(gnt_a), 32'b100);
    step(3'b001, 1'b1);
    check("r035_drop", 32'({gnt_a, out_valid_a}), 32'b1000);
    step(3'b001, 1'b1);
    check("r035_idle", 32'(gnt_a), 32'b000);
    step(3'b001, 1'b1);
    check("r035_gnt0", 32'(gnt_a), 32'b001);

    // Reset during owner 1's burst; requester 0 wins afterwards.
    for (int i = 0; i < 5; i++) step(3'b011, 1'b1);
    check("r036_own1", 32'(gnt_a), 32'b010);
    async_reset();
    step(3'b011, 1'b1);
    check("r036_idle", 32'(gnt_a), 32'b000);
    step(3'b011, 1'b1);
    check("r036_first", 32'(gnt_a), 32'b001);

    // All requesting: grants rotate 0, 1, 2, 0 with a gap between owners.
    @(negedge clk);
    async_reset();
    exp_q.push_back(3'b001); exp_q.push_back(3'b010);
    exp_q.push_back(3'b100); exp_q.push_back(3'b001);
    step(3'b111, 1'b1);
    while (exp_q.size() > 0) begin
      logic [2:0] e;
      e = exp_q.pop_front();
      for (int i = 0; i < 4; i++) begin
        step(3'b111, 1'b1);
        check("r033_rr", 32'(gnt_a), 32'(e));
      end
      step(3'b111, 1'b1);
      check("r033_gap", 32'(gnt_a), 32'b000);
    end

    // Random traffic: requests toggle occasionally, with random ready and data.
    cur_req = 3'b000;
    for (int n = 0; n < 800; n++) begin
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 5) == 0) cur_req[b] = ~cur_req[b];
      end
      data0 = 8'($urandom); data1 = 8'($urandom); data2 = 8'($urandom);
      step(cur_req, ($urandom_range(0, 3) != 0));
      if ((n % 200) == 199) begin
        @(negedge clk);
        async_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: width of each requester data bus and of the shared output.
REQ-002 Parameter MAX_BEATS, default 4: maximum transfers per grant; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  3  request per requester 0..2; a requester holds it high while it has data.
REQ-006 data0, data1, data2  input  WIDTH each  requester data buses.
REQ-007 out_ready  input  1  sink accepts out_data this cycle.
REQ-008 gnt  output  3  one-hot grant, registered; all-zero when no owner.
REQ-009 out_data  output  WIDTH  shared-mux output: data of granted requester, zero when gnt is zero.
REQ-010 out_valid  output  1  out_data is valid this cycle.
REQ-011 busy  output  1  high while in GRANT state.

Function
REQ-012 FSM has exactly two states: IDLE and GRANT.
REQ-013 Transfer ("beat") occurs in a cycle where out_valid and out_ready are both 1.
REQ-014 out_valid = (state == GRANT) and req[owner], combinational from registered state and live req.
REQ-015 out_data is the 3:1 mux of data0/1/2 selected by the registered gnt; it is combinational from the data inputs.
REQ-016 IDLE with req != 0: next state GRANT; gnt loads the one-hot winner; beat counter clears to 0.
REQ-017 IDLE with req == 0: stay IDLE, gnt stays 0.
REQ-018 Winner is round-robin: first set bit of req scanning from index (last+1) mod 3 upward with wrap, where last is the registered index of the previous owner.
REQ-019 GRANT, beat with beat counter == MAX_BEATS-1: next state IDLE, gnt cleared, last <= owner.
REQ-020 GRANT, beat with counter < MAX_BEATS-1: stay GRANT, counter increments by 1.
REQ-021 GRANT, req[owner] == 0: next state IDLE, gnt cleared, last <= owner; counter value discarded.
REQ-022 GRANT, req[owner] == 1 and out_ready == 0: hold state, gnt and counter unchanged (no timeout).
REQ-023 Requests from non-owners during GRANT are ignored; they are not queued and are re-evaluated in IDLE.
REQ-024 Every release passes through exactly one IDLE cycle; latency from req rising (IDLE, no competitors) to gnt high is 1 cycle.
REQ-025 Beat counter is 4 bits wide and never exceeds MAX_BEATS-1.
REQ-026 With MAX_BEATS = 1, every beat releases the grant.
REQ-027 gnt has at most one bit set in every cycle.

Reset
REQ-028 rst_n low forces immediately, regardless of clk: state IDLE, gnt = 000, beat counter = 0, last = 2.
REQ-029 During reset, out_valid = 0, busy = 0, out_data = 0.
REQ-030 Reset asserted mid-grant abandons the burst; after release, the first arbitration scans from requester 0.
REQ-031 The first rising edge after rst_n goes high may perform an IDLE arbitration.

Verification
REQ-032 Reset, then req=001, out_ready=1, data0=8'hA5 -> gnt=001 after 1 edge, out_valid=1, out_data=A5; 4 beats, then gnt=000 for 1 cycle, then gnt=001 again.
REQ-033 req=111 held, out_ready=1 -> grants in order 001, 010, 100, 001, each lasting 4 beats and separated by one IDLE cycle.
REQ-034 Owner 1 granted, out_ready=0 for 5 cycles -> gnt=010, out_valid=1, counter frozen; on out_ready=1 the remaining beats complete, for 4 beats total.
REQ-035 Owner 2 drops req after 2 beats while req[0]=1 -> IDLE next cycle, then gnt=001 (scan starts at 0).
REQ-036 rst_n pulsed low mid-burst of owner 1 with req=011 -> outputs zero asynchronously; after release, first grant is 001.
REQ-037 All cycles: gnt one-hot or zero, and out_data equals the selected data bus (or 0 when gnt=000).
